reg_file_np: RTL and testbench



---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_read_mux.sv | 44 ++++
 rtl/reg_file_np.sv | 69 ++++++
 tb/tb_reg_file_np.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the parametrised register file.
package rf_pkg;

  localparam int unsigned ZERO_REG     = 0;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = 5;

  // Smallest index width able to address n registers (at least 1 bit).
  function automatic int unsigned min_addr_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rf_read_mux.sv
// One register-file read port: NUM_REGS:1 select with zero/out-of-range handling.
// With RF_BYPASS_EN defined, a qualified same-cycle write is forwarded to the port.
module rf_read_mux
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic [(NUM_REGS-1)*DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]              raddr_i,
`ifdef RF_BYPASS_EN
  input  logic                           byp_en_i,
  input  logic [ADDR_W-1:0]              waddr_i,
  input  logic [DATA_W-1:0]              wdata_i,
`endif
  output logic [DATA_W-1:0]              rdata_o
);

  logic [DATA_W-1:0] sel_c;

  // Entry i lives at slot i-1; index 0 and unmatched indices fall through to zero.
  always_comb begin
    sel_c = '0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      if (raddr_i == ADDR_W'(i)) begin
        sel_c = regs_i[(i-1)*DATA_W +: DATA_W];
      end
    end
  end

`ifdef RF_BYPASS_EN
  // byp_en_i already excludes reset, the zero register and out-of-range writes.
  always_comb begin
    rdata_o = sel_c;
    if (byp_en_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end
`else
  assign rdata_o = sel_c;
`endif

endmodule

// File: rtl/reg_file_np.sv
// Parametrised register file with hardwired zero register and NUM_RD read ports.
// Same-cycle write-to-read forwarding is compiled in when RF_BYPASS_EN is defined.
module reg_file_np
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  if ((min_addr_w(NUM_REGS) > ADDR_W) || (NUM_REGS < 2) || (NUM_RD < 1) || (NUM_RD > 4))
  begin : g_cfg_err
    $error("reg_file_np: illegal NUM_REGS/ADDR_W/NUM_RD combination");
  end

  logic [DATA_W-1:0]              mem_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]              mem_d [1:NUM_REGS-1];
  logic [(NUM_REGS-1)*DATA_W-1:0] regs_flat_c;
  logic                           wr_en_c;

  assign wr_en_c = we && !rst && (waddr != ADDR_W'(ZERO_REG)) && (32'(waddr) < NUM_REGS);

  // Reset clears every entry and overrides any write in the same cycle.
  always_comb begin
    mem_d = mem_q;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      if (rst) begin
        mem_d[i] = '0;
      end else if (wr_en_c && (waddr == ADDR_W'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat_c[(g-1)*DATA_W +: DATA_W] = mem_q[g];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_mux #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_rd (
      .regs_i   (regs_flat_c),
      .raddr_i  (raddr[k*ADDR_W +: ADDR_W]),
`ifdef RF_BYPASS_EN
      .byp_en_i (wr_en_c),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
`endif
      .rdata_o  (rdata[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_np.sv
// Self-checking bench for reg_file_np: a 32x32 two-port instance and a
// 12x16 four-port instance (4-bit index, so indices 12..15 are out of range).
module tb_reg_file_np;

  localparam int unsigned DW_A = 32, NR_A = 32, AW_A = 5, RD_A = 2;
  localparam int unsigned DW_B = 16, NR_B = 12, AW_B = 4, RD_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     we_a, we_b;
  logic [AW_A-1:0]          waddr_a;
  logic [AW_B-1:0]          waddr_b;
  logic [DW_A-1:0]          wdata_a;
  logic [DW_B-1:0]          wdata_b;
  logic [RD_A*AW_A-1:0]     raddr_a;
  logic [RD_B*AW_B-1:0]     raddr_b;
  logic [RD_A*DW_A-1:0]     rdata_a;
  logic [RD_B*DW_B-1:0]     rdata_b;

  reg_file_np #(.DATA_W(DW_A), .NUM_REGS(NR_A), .ADDR_W(AW_A), .NUM_RD(RD_A)) u_dut_a (
    .clk(clk), .rst(rst), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .raddr(raddr_a), .rdata(rdata_a)
  );

  reg_file_np #(.DATA_W(DW_B), .NUM_REGS(NR_B), .ADDR_W(AW_B), .NUM_RD(RD_B)) u_dut_b (
    .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .raddr(raddr_b), .rdata(rdata_b)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [DW_A-1:0] model_a [NR_A];
  logic [DW_B-1:0] model_b [NR_B];

  // Architectural read value of the 32-entry instance for the current inputs.
  function automatic logic [31:0] exp_a(input int unsigned idx);
    if (idx == 0 || idx >= NR_A) return '0;
`ifdef RF_BYPASS_EN
    if (we_a && !rst && (32'(waddr_a) == idx)) return wdata_a;
`endif
    return model_a[idx[4:0]];
  endfunction

  function automatic logic [31:0] exp_b(input int unsigned idx);
    if (idx == 0 || idx >= NR_B) return '0;
`ifdef RF_BYPASS_EN
    if (we_b && !rst && (32'(waddr_b) == idx)) return 32'(wdata_b);
`endif
    return 32'(model_b[idx[3:0]]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every read port of both instances; undefined (pre-reset) entries are skipped.
  task automatic check_all();
    int unsigned idx;
    logic [31:0] e;
    for (int k = 0; k < int'(RD_A); k++) begin
      idx = 32'(raddr_a[k*AW_A +: AW_A]);
      e   = exp_a(idx);
      if (!$isunknown(e))
        chk($sformatf("a_port%0d_r%0d", k, idx), rdata_a[k*DW_A +: DW_A], e);
    end
    for (int k = 0; k < int'(RD_B); k++) begin
      idx = 32'(raddr_b[k*AW_B +: AW_B]);
      e   = exp_b(idx);
      if (!$isunknown(e))
        chk($sformatf("b_port%0d_r%0d", k, idx), 32'(rdata_b[k*DW_B +: DW_B]), e);
    end
  endtask

  // Check mid-cycle, then apply the architectural effect of the edge to the models.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst) begin
      foreach (model_a[i]) model_a[i] = '0;
      foreach (model_b[i]) model_b[i] = '0;
    end else begin
      if (we_a && waddr_a != 0 && 32'(waddr_a) < NR_A) model_a[waddr_a] = wdata_a;
      if (we_b && waddr_b != 0 && 32'(waddr_b) < NR_B) model_b[waddr_b] = wdata_b;
    end
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; waddr_a = '0; wdata_a = '0;
    we_b = 1'b0; waddr_b = '0; wdata_b = '0;
  endtask

  task automatic rd_a(input int unsigned i0, input int unsigned i1);
    raddr_a[0 +: AW_A]    = AW_A'(i0);
    raddr_a[AW_A +: AW_A] = AW_A'(i1);
  endtask

  task automatic rd_b(input int unsigned i0, input int unsigned i1,
                      input int unsigned i2, input int unsigned i3);
    raddr_b[0 +: AW_B]      = AW_B'(i0);
    raddr_b[AW_B +: AW_B]   = AW_B'(i1);
    raddr_b[2*AW_B +: AW_B] = AW_B'(i2);
    raddr_b[3*AW_B +: AW_B] = AW_B'(i3);
  endtask

  initial begin
    foreach (model_a[i]) model_a[i] = 'x;
    foreach (model_b[i]) model_b[i] = 'x;
    rst = 1'b0;
    idle();

    // Before any reset: zero register and out-of-range indices already read 0.
    rd_a(0, 0);
    rd_b(0, 12, 13, 15);
    cycle();

    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Post-reset sweep of every index on every port.
    for (int i = 0; i < 32; i++) begin
      rd_a(i, 31 - i);
      rd_b(i % 16, (i + 5) % 16, (i + 10) % 16, 15 - (i % 16));
      cycle();
    end

    // Write 0xDEADBEEF to r5 and read it back on both ports.
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF;
    rd_a(5, 5);
    cycle();
    idle();
    cycle();

    // Writes to the zero register are discarded.
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF;
    rd_a(0, 5);
    cycle();
    idle();
    cycle();

    // Out-of-range write on the 12-entry instance must not alias onto r4.
    we_b = 1'b1; waddr_b = 4'd4; wdata_b = 16'h4444;
    cycle();
    we_b = 1'b1; waddr_b = 4'd13; wdata_b = 16'h1234;
    rd_b(13, 4, 1, 12);
    cycle();
    idle();
    cycle();

    // Same-cycle write/read of r7: forwarded value or old contents depending on build.
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hA5A5A5A5;
    rd_a(5, 7);
    cycle();
    idle();
    cycle();

    // Reset wins over a simultaneous write; no forwarding while rst is high.
    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h11;
    rd_a(9, 7);
    cycle();
    rst = 1'b1; we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h22;
    rd_a(9, 9);
    cycle();
    rst = 1'b0;
    idle();
    cycle();

    // Fill r1..r11 of the four-port instance, then read four distinct entries at once.
    for (int i = 1; i < int'(NR_B); i++) begin
      we_b = 1'b1; waddr_b = AW_B'(i); wdata_b = DW_B'(16'h1000 + i);
      rd_b(i, 0, 15, i);
      cycle();
    end
    idle();
    rd_b(1, 4, 7, 11);
    cycle();
    rd_b(11, 2, 2, 9);
    cycle();

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 40) == 0);
      we_a    = 1'($urandom_range(0, 1));
      waddr_a = AW_A'($urandom_range(0, 31));
      wdata_a = DW_A'($urandom);
      we_b    = 1'($urandom_range(0, 1));
      waddr_b = AW_B'($urandom_range(0, 15));
      wdata_b = DW_B'($urandom);
      if ($urandom_range(0, 3) == 0) rd_a(waddr_a, $urandom_range(0, 31));
      else rd_a($urandom_range(0, 31), $urandom_range(0, 31));
      rd_b($urandom_range(0, 15), waddr_b, $urandom_range(0, 15), $urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
